// File: rtl/imsic_msi_receiver.sv
// AXI4-Lite MSI responder: decodes writes into (hart, eiid) set-pending requests queued for the IMSIC files.
// Define IMSIC_BE_EN to also accept the big-endian seteipnum_be register at page offset 0x004.
module imsic_msi_receiver #(
  parameter int unsigned NrHarts   = 4,
  parameter int unsigned NrIntp    = 64,
  parameter logic [31:0] BaseAddr  = 32'h2400_0000,
  parameter int unsigned FifoDepth = 4,
  localparam int unsigned HartW    = (NrHarts > 1) ? $clog2(NrHarts) : 1,
  localparam int unsigned IdW      = $clog2(NrIntp)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_aw_valid,
  output logic             o_aw_ready,
  input  logic [31:0]      i_aw_addr,
  input  logic             i_w_valid,
  output logic             o_w_ready,
  input  logic [31:0]      i_w_data,
  input  logic [3:0]       i_w_strb,
  output logic             o_b_valid,
  input  logic             i_b_ready,
  output logic [1:0]       o_b_resp,
  output logic             o_set_valid,
  input  logic             i_set_ready,
  output logic [HartW-1:0] o_set_hart,
  output logic [IdW-1:0]   o_set_eiid,
  output logic             o_drop
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;

  typedef enum logic [1:0] {IDLE, WAIT_W, WAIT_AW, RESP} state_e;

  state_e      state;
  logic [31:0] addr_q;
  logic [31:0] data_q;
  logic [3:0]  strb_q;

  logic [HartW+IdW-1:0] mem [FifoDepth];
  logic [PtrW-1:0]      wr_ptr;
  logic [PtrW-1:0]      rd_ptr;
  logic [CntW-1:0]      count;

  logic        has_space;
  logic        aw_hs;
  logic        w_hs;
  logic        commit;
  logic        push;
  logic        pop;
  logic [31:0] cur_addr;
  logic [31:0] cur_data;
  logic [3:0]  cur_strb;
  logic [31:0] off;
  logic [19:0] page;
  logic        dec_err;
  logic        offset_ok;
  logic [31:0] eiid_raw;
  logic        wr_valid;

  assign has_space = (count < CntW'(FifoDepth));

  // Only one transaction is ever in flight, so space seen in IDLE stays reserved until commit.
  always_comb begin
    o_aw_ready = 1'b0;
    o_w_ready  = 1'b0;
    if (!i_rst) begin
      case (state)
        IDLE: begin
          o_aw_ready = has_space;
          o_w_ready  = has_space;
        end
        WAIT_W:  o_w_ready  = 1'b1;
        WAIT_AW: o_aw_ready = 1'b1;
        default: ;
      endcase
    end
  end

  assign aw_hs  = i_aw_valid && o_aw_ready;
  assign w_hs   = i_w_valid && o_w_ready;
  assign commit = ((state == IDLE) && aw_hs && w_hs) ||
                  ((state == WAIT_W) && w_hs) ||
                  ((state == WAIT_AW) && aw_hs);

  assign cur_addr = (state == WAIT_W)  ? addr_q : i_aw_addr;
  assign cur_data = (state == WAIT_AW) ? data_q : i_w_data;
  assign cur_strb = (state == WAIT_AW) ? strb_q : i_w_strb;

  assign off     = cur_addr - BaseAddr;
  assign page    = off[31:12];
  assign dec_err = (cur_addr < BaseAddr) || ({12'b0, page} >= 32'(NrHarts));

  always_comb begin
    eiid_raw  = cur_data;
    offset_ok = (off[11:0] == 12'h000);
`ifdef IMSIC_BE_EN
    if (off[11:0] == 12'h004) begin
      eiid_raw  = {cur_data[7:0], cur_data[15:8], cur_data[23:16], cur_data[31:24]};
      offset_ok = 1'b1;
    end
`endif
  end

  assign wr_valid = !dec_err && offset_ok && (cur_strb == 4'hF) &&
                    (eiid_raw != 32'd0) && (eiid_raw < 32'(NrIntp));

  assign push = commit && wr_valid;
  assign pop  = o_set_valid && i_set_ready;

  // Write channel FSM; the response and drop pulse are decided on the commit edge.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      addr_q    <= '0;
      data_q    <= '0;
      strb_q    <= '0;
      o_b_valid <= 1'b0;
      o_b_resp  <= 2'b00;
      o_drop    <= 1'b0;
    end else begin
      o_drop <= 1'b0;
      if (commit) begin
        state     <= RESP;
        o_b_valid <= 1'b1;
        o_b_resp  <= dec_err ? 2'b11 : 2'b00;
        o_drop    <= !dec_err && !wr_valid;
      end else begin
        case (state)
          IDLE: begin
            if (aw_hs) begin
              addr_q <= i_aw_addr;
              state  <= WAIT_W;
            end else if (w_hs) begin
              data_q <= i_w_data;
              strb_q <= i_w_strb;
              state  <= WAIT_AW;
            end
          end
          RESP: begin
            if (i_b_ready) begin
              o_b_valid <= 1'b0;
              o_b_resp  <= 2'b00;
              state     <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Set-pending queue; FifoDepth is a power of two so the pointers wrap on overflow.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(FifoDepth); i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (push) begin
        mem[wr_ptr] <= {page[HartW-1:0], eiid_raw[IdW-1:0]};
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  assign o_set_valid = (count != '0);
  assign o_set_hart  = mem[rd_ptr][HartW+IdW-1:IdW];
  assign o_set_eiid  = mem[rd_ptr][IdW-1:0];

endmodule

// File: tb/tb_imsic_msi_receiver.sv
// Directed bench for imsic_msi_receiver; a scoreboard queue holds the expected set-pending requests.
module tb_imsic_msi_receiver;

  localparam int unsigned HartW = 2;
  localparam int unsigned IdW   = 6;

  logic             i_clk = 1'b0;
  logic             i_rst;
  logic             i_aw_valid;
  logic             o_aw_ready;
  logic [31:0]      i_aw_addr;
  logic             i_w_valid;
  logic             o_w_ready;
  logic [31:0]      i_w_data;
  logic [3:0]       i_w_strb;
  logic             o_b_valid;
  logic             i_b_ready;
  logic [1:0]       o_b_resp;
  logic             o_set_valid;
  logic             i_set_ready;
  logic [HartW-1:0] o_set_hart;
  logic [IdW-1:0]   o_set_eiid;
  logic             o_drop;

  int          checks = 0;
  int          passes = 0;
  int          fails  = 0;
  logic [31:0] sb[$];

  imsic_msi_receiver dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_aw_valid  (i_aw_valid),
    .o_aw_ready  (o_aw_ready),
    .i_aw_addr   (i_aw_addr),
    .i_w_valid   (i_w_valid),
    .o_w_ready   (o_w_ready),
    .i_w_data    (i_w_data),
    .i_w_strb    (i_w_strb),
    .o_b_valid   (o_b_valid),
    .i_b_ready   (i_b_ready),
    .o_b_resp    (o_b_resp),
    .o_set_valid (o_set_valid),
    .i_set_ready (i_set_ready),
    .o_set_hart  (o_set_hart),
    .o_set_eiid  (o_set_eiid),
    .o_drop      (o_drop)
  );

  always #5 i_clk = ~i_clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic waitReady(input bit want_aw, input bit want_w);
    for (int i = 0; i < 100; i++) begin
      @(negedge i_clk);
      if ((!want_aw || o_aw_ready) && (!want_w || o_w_ready)) return;
    end
    checkOutput("handshake_timeout", 32'd0, 32'd1);
  endtask

  task automatic collectResponse(output logic [1:0] resp, output logic drop, output logic sv);
    @(negedge i_clk);
    checkOutput("b_valid", {31'd0, o_b_valid}, 32'd1);
    resp = o_b_resp;
    drop = o_drop;
    sv   = o_set_valid;
    tick();
    i_b_ready = 1'b1;
    tick();
    i_b_ready = 1'b0;
  endtask

  // mode 0: AW and W together, mode 1: W first, mode 2: AW first
  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] data,
                               input logic [3:0] strb, input int mode,
                               output logic [1:0] resp, output logic drop, output logic sv);
    i_aw_addr = addr;
    i_w_data  = data;
    i_w_strb  = strb;
    case (mode)
      0: begin
        i_aw_valid = 1'b1;
        i_w_valid  = 1'b1;
        waitReady(1'b1, 1'b1);
        tick();
        i_aw_valid = 1'b0;
        i_w_valid  = 1'b0;
      end
      1: begin
        i_w_valid = 1'b1;
        waitReady(1'b0, 1'b1);
        tick();
        i_w_valid = 1'b0;
        tick();
        i_aw_valid = 1'b1;
        waitReady(1'b1, 1'b0);
        tick();
        i_aw_valid = 1'b0;
      end
      default: begin
        i_aw_valid = 1'b1;
        waitReady(1'b1, 1'b0);
        tick();
        i_aw_valid = 1'b0;
        tick();
        i_w_valid = 1'b1;
        waitReady(1'b0, 1'b1);
        tick();
        i_w_valid = 1'b0;
      end
    endcase
    collectResponse(resp, drop, sv);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 100 && sb.size() != 0; i++) begin
      @(negedge i_clk);
    end
    tick();
    checkOutput("sb_empty", sb.size(), 32'd0);
  endtask

  // Every accepted set-pending request is matched against the oldest expectation.
  always @(negedge i_clk) begin
    if (!i_rst && o_set_valid && i_set_ready) begin
      if (sb.size() == 0) begin
        checkOutput("set_unexpected", {16'd0, 8'(o_set_hart), 8'(o_set_eiid)}, 32'hFFFF_FFFF);
      end else begin
        checkOutput("set_pair", (32'(o_set_hart) << 16) | 32'(o_set_eiid), sb.pop_front());
      end
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [1:0] resp;
    logic       drop;
    logic       sv;

    i_rst       = 1'b1;
    i_aw_valid  = 1'b0;
    i_aw_addr   = '0;
    i_w_valid   = 1'b0;
    i_w_data    = '0;
    i_w_strb    = '0;
    i_b_ready   = 1'b0;
    i_set_ready = 1'b1;

    repeat (3) tick();
    @(negedge i_clk);
    checkOutput("rst_aw_ready", {31'd0, o_aw_ready}, 32'd0);
    checkOutput("rst_w_ready", {31'd0, o_w_ready}, 32'd0);
    checkOutput("rst_b_valid", {31'd0, o_b_valid}, 32'd0);
    checkOutput("rst_set_valid", {31'd0, o_set_valid}, 32'd0);
    checkOutput("rst_drop", {31'd0, o_drop}, 32'd0);
    tick();
    i_rst = 1'b0;
    tick();
    @(negedge i_clk);
    checkOutput("idle_aw_ready", {31'd0, o_aw_ready}, 32'd1);
    tick();

    $display("[TB] valid write hart 2 eiid 5");
    sb.push_back((32'd2 << 16) | 32'd5);
    applyStimulus(32'h2400_2000, 32'd5, 4'hF, 0, resp, drop, sv);
    checkOutput("t1_resp", {30'd0, resp}, 32'd0);
    checkOutput("t1_drop", {31'd0, drop}, 32'd0);
    checkOutput("t1_set_valid", {31'd0, sv}, 32'd1);

    $display("[TB] page beyond NrHarts");
    applyStimulus(32'h2400_4000, 32'd5, 4'hF, 0, resp, drop, sv);
    checkOutput("decerr_resp", {30'd0, resp}, 32'd3);
    checkOutput("decerr_drop", {31'd0, drop}, 32'd0);
    checkOutput("decerr_set_valid", {31'd0, sv}, 32'd0);

    applyStimulus(32'h23FF_F000, 32'd5, 4'hF, 0, resp, drop, sv);
    checkOutput("below_resp", {30'd0, resp}, 32'd3);
    checkOutput("below_drop", {31'd0, drop}, 32'd0);

    $display("[TB] W before AW with out-of-range identities");
    applyStimulus(32'h2400_1000, 32'd64, 4'hF, 1, resp, drop, sv);
    checkOutput("eiid64_resp", {30'd0, resp}, 32'd0);
    checkOutput("eiid64_drop", {31'd0, drop}, 32'd1);
    checkOutput("eiid64_set_valid", {31'd0, sv}, 32'd0);
    applyStimulus(32'h2400_1000, 32'd0, 4'hF, 1, resp, drop, sv);
    checkOutput("eiid0_resp", {30'd0, resp}, 32'd0);
    checkOutput("eiid0_drop", {31'd0, drop}, 32'd1);
    checkOutput("eiid0_set_valid", {31'd0, sv}, 32'd0);

    applyStimulus(32'h2400_3000, 32'd7, 4'h7, 0, resp, drop, sv);
    checkOutput("strb_resp", {30'd0, resp}, 32'd0);
    checkOutput("strb_drop", {31'd0, drop}, 32'd1);
    applyStimulus(32'h2400_3008, 32'd7, 4'hF, 2, resp, drop, sv);
    checkOutput("rsvd_resp", {30'd0, resp}, 32'd0);
    checkOutput("rsvd_drop", {31'd0, drop}, 32'd1);
    checkOutput("rsvd_set_valid", {31'd0, sv}, 32'd0);

    $display("[TB] big-endian register offset");
`ifdef IMSIC_BE_EN
    sb.push_back(32'd3);
    applyStimulus(32'h2400_0004, 32'h0300_0000, 4'hF, 0, resp, drop, sv);
    checkOutput("be_resp", {30'd0, resp}, 32'd0);
    checkOutput("be_drop", {31'd0, drop}, 32'd0);
    checkOutput("be_set_valid", {31'd0, sv}, 32'd1);
`else
    applyStimulus(32'h2400_0004, 32'h0300_0000, 4'hF, 0, resp, drop, sv);
    checkOutput("be_resp", {30'd0, resp}, 32'd0);
    checkOutput("be_drop", {31'd0, drop}, 32'd1);
    checkOutput("be_set_valid", {31'd0, sv}, 32'd0);
`endif
    waitDrain();

    $display("[TB] fill the queue with the interrupt file stalled");
    i_set_ready = 1'b0;
    for (int h = 0; h < 4; h++) begin
      sb.push_back((32'(h) << 16) | 32'(10 + h));
      applyStimulus(32'h2400_0000 + (32'(h) << 12), 32'(10 + h), 4'hF, h % 3, resp, drop, sv);
      checkOutput("fill_resp", {30'd0, resp}, 32'd0);
      checkOutput("fill_set_valid", {31'd0, sv}, 32'd1);
    end
    sb.push_back((32'd1 << 16) | 32'd63);
    i_aw_addr  = 32'h2400_1000;
    i_w_data   = 32'd63;
    i_w_strb   = 4'hF;
    i_aw_valid = 1'b1;
    i_w_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge i_clk);
      checkOutput("full_aw_ready", {31'd0, o_aw_ready}, 32'd0);
      checkOutput("full_w_ready", {31'd0, o_w_ready}, 32'd0);
    end
    tick();
    i_set_ready = 1'b1;
    waitReady(1'b1, 1'b1);
    tick();
    i_aw_valid = 1'b0;
    i_w_valid  = 1'b0;
    collectResponse(resp, drop, sv);
    checkOutput("fifth_resp", {30'd0, resp}, 32'd0);
    checkOutput("fifth_drop", {31'd0, drop}, 32'd0);
    waitDrain();

    $display("[TB] reset while waiting for W with two entries queued");
    i_set_ready = 1'b0;
    applyStimulus(32'h2400_3000, 32'd1, 4'hF, 0, resp, drop, sv);
    applyStimulus(32'h2400_0000, 32'd2, 4'hF, 0, resp, drop, sv);
    i_aw_addr  = 32'h2400_1000;
    i_aw_valid = 1'b1;
    waitReady(1'b1, 1'b0);
    tick();
    i_aw_valid = 1'b0;
    @(negedge i_clk);
    checkOutput("wait_w_w_ready", {31'd0, o_w_ready}, 32'd1);
    checkOutput("wait_w_aw_ready", {31'd0, o_aw_ready}, 32'd0);
    checkOutput("wait_w_set_valid", {31'd0, o_set_valid}, 32'd1);
    tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    sb.delete();
    @(negedge i_clk);
    checkOutput("mid_rst_set_valid", {31'd0, o_set_valid}, 32'd0);
    checkOutput("mid_rst_b_valid", {31'd0, o_b_valid}, 32'd0);
    checkOutput("mid_rst_aw_ready", {31'd0, o_aw_ready}, 32'd1);
    tick();

    i_set_ready = 1'b1;
    sb.push_back((32'd3 << 16) | 32'd42);
    applyStimulus(32'h2400_3000, 32'd42, 4'hF, 2, resp, drop, sv);
    checkOutput("post_rst_resp", {30'd0, resp}, 32'd0);
    checkOutput("post_rst_drop", {31'd0, drop}, 32'd0);
    waitDrain();

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
